// File: rtl/lfsr_rr_sched_if.sv
// Handshake bundle between the shared-LFSR scheduler and its requesters.
// Latency: none (wires only).
// Backpressure: none here; a requester holds req until its one-cycle ack.
//
// Signals:
//   req       requester -> scheduler  N_REQ  level request per requester
//   seed_load requester -> scheduler  1      load seed (honoured only when idle)
//   seed      requester -> scheduler  26     seed, q[1] (MSB) .. q[26] (LSB)
//   ack       scheduler -> requester  N_REQ  one-hot pulse, rnd_out valid with it
//   grant_id  scheduler -> requester  GW     index of the requester being served
//   rnd_out   scheduler -> requester  26     delivered word
//   busy      scheduler -> requester  1      high while stepping / acking
interface lfsr_rr_sched_if #(
  parameter int N_REQ = 4
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic             seed_load;
  logic [25:0]      seed;
  logic [N_REQ-1:0] ack;
  logic [GW-1:0]    grant_id;
  logic [25:0]      rnd_out;
  logic             busy;

  // Requester / client side.
  modport master (
    output req,
    output seed_load,
    output seed,
    input  ack,
    input  grant_id,
    input  rnd_out,
    input  busy
  );

  // Scheduler side.
  modport slave (
    input  req,
    input  seed_load,
    input  seed,
    output ack,
    output grant_id,
    output rnd_out,
    output busy
  );
endinterface

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one 26-bit Galois LFSR among N_REQ requesters.
// Latency: STEPS cycles from the req sampling edge to ack; one word per STEPS+2 cycles.
// Backpressure: requests are level-held and sampled only in IDLE; seed_load while busy is dropped.
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   bus            lfsr_rr_sched_if.slave (req, seed_load, seed -> ack, grant_id, rnd_out, busy)
//   words_served   [15:0] count of delivered words, wraps     (only with LFSR_RR_SCHED_CNT_EN)
//   seed_seen      sticky flag, set by an accepted seed_load  (only with LFSR_RR_SCHED_CNT_EN)
//
// Optional feature macro: LFSR_RR_SCHED_CNT_EN adds words_served and seed_seen.
//
// Bit ordering: the spec-style register q[1:26] (q[1] = MSB) is held as
// lfsr_q[25:0], so q[k] lives at lfsr_q[26-k] and q[26] is lfsr_q[0].
module lfsr_rr_sched #(
  parameter int N_REQ = 4,
  parameter int STEPS = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lfsr_rr_sched_if.slave        bus
`ifdef LFSR_RR_SCHED_CNT_EN
  ,
  output logic [15:0]           words_served,
  output logic                  seed_seen
`endif
);

  localparam int GW    = $clog2(N_REQ);
  localparam int CNT_W = 6;

  // Feedback mask: q[26] folds into q[1], q[2], q[8] and q[9] while the rest
  // of the register shifts one place towards q[26].
  localparam logic [25:0] TAPS     = 26'h3060000;
  localparam logic [25:0] LFSR_ONE = 26'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [25:0]      lfsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GW-1:0]    ptr_q;
  logic [GW-1:0]    grant_q;
  logic [N_REQ-1:0] ack_q;
  logic [25:0]      rnd_q;
  logic             busy_q;

  // ---------------------------------------------------------------------------
  // Next-value helpers
  // ---------------------------------------------------------------------------
  logic [25:0]      lfsr_step_d;
  logic [25:0]      seed_val_d;
  logic [N_REQ-1:0] ack_d;

  // One LFSR step. All-zero is a lock-up state for a Galois LFSR, so it is
  // replaced by the reset value rather than stepped.
  always_comb begin
    lfsr_step_d = LFSR_ONE;
    if (lfsr_q != '0) begin
      lfsr_step_d = {1'b0, lfsr_q[25:1]} ^ (lfsr_q[0] ? TAPS : 26'd0);
    end
  end

  // A zero seed would lock the LFSR up, so it is mapped to the reset value.
  always_comb begin
    seed_val_d = bus.seed;
    if (bus.seed == '0) begin
      seed_val_d = LFSR_ONE;
    end
  end

  // One-hot ack for the requester currently being served.
  always_comb begin
    ack_d = N_REQ'(1) << grant_q;
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first asserted request strictly above ptr_q, else the
  // lowest asserted request overall (the wrap). Scanning downward lets the
  // last hit in each class be the lowest index of that class.
  // ---------------------------------------------------------------------------
  logic          pick_vld;
  logic [GW-1:0] pick_idx;
  logic          hi_vld;
  logic [GW-1:0] hi_idx;
  logic [GW-1:0] lo_idx;

  always_comb begin
    hi_vld   = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    pick_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        pick_vld = 1'b1;
        lo_idx   = GW'(i);
        if (i > int'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = GW'(i);
        end
      end
    end
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  // ---------------------------------------------------------------------------
  // Optional service counters
  // ---------------------------------------------------------------------------
`ifdef LFSR_RR_SCHED_CNT_EN
  logic [15:0] words_q;
  logic        seed_seen_q;
`endif

  // ---------------------------------------------------------------------------
  // Controller. All outputs are registered; ack and rnd_out are loaded on the
  // last STEP edge so that they are valid together for exactly the ACK cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_ONE;
      cnt_q       <= '0;
      ptr_q       <= GW'(N_REQ - 1);
      grant_q     <= '0;
      ack_q       <= '0;
      rnd_q       <= '0;
      busy_q      <= 1'b0;
`ifdef LFSR_RR_SCHED_CNT_EN
      words_q     <= '0;
      seed_seen_q <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          // Seed takes priority; a concurrent request simply waits a cycle.
          if (bus.seed_load) begin
            lfsr_q <= seed_val_d;
`ifdef LFSR_RR_SCHED_CNT_EN
            seed_seen_q <= 1'b1;
`endif
          end else if (pick_vld) begin
            grant_q <= pick_idx;
            cnt_q   <= CNT_W'(STEPS - 1);
            busy_q  <= 1'b1;
            state_q <= S_STEP;
          end
        end

        S_STEP: begin
          lfsr_q <= lfsr_step_d;
          if (cnt_q == '0) begin
            ack_q   <= ack_d;
            rnd_q   <= lfsr_step_d;
            state_q <= S_ACK;
`ifdef LFSR_RR_SCHED_CNT_EN
            words_q <= words_q + 16'd1;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_ACK: begin
          // The winner drops to lowest priority for the next arbitration.
          ptr_q   <= grant_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.rnd_out  = rnd_q;
  assign bus.busy     = busy_q;

`ifdef LFSR_RR_SCHED_CNT_EN
  assign words_served = words_q;
  assign seed_seen    = seed_seen_q;
`endif

endmodule

// File: tb/tb_lfsr_rr_sched.sv
module tb_lfsr_rr_sched;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_pass;

  lfsr_rr_sched_if #(.N_REQ(4)) bus  ();
  lfsr_rr_sched_if #(.N_REQ(4)) bus1 ();

`ifdef LFSR_RR_SCHED_CNT_EN
  logic [15:0] words_served;
  logic        seed_seen;
  logic [15:0] words_served1;
  logic        seed_seen1;
`endif

  lfsr_rr_sched #(.N_REQ(4), .STEPS(26)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef LFSR_RR_SCHED_CNT_EN
    ,
    .words_served (words_served),
    .seed_seen    (seed_seen)
`endif
  );

  lfsr_rr_sched #(.N_REQ(4), .STEPS(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus1)
`ifdef LFSR_RR_SCHED_CNT_EN
    ,
    .words_served (words_served1),
    .seed_seen    (seed_seen1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR written directly in q[1:26] notation (q[1] is the MSB).
  function automatic logic [25:0] ref_step(input logic [25:0] v);
    logic [1:26] q;
    logic [1:26] n;
    q = v;
    if (q == '0) begin
      n = 26'd1;
    end else begin
      n[1]     = q[26];
      n[2]     = q[1] ^ q[26];
      n[3:7]   = q[2:6];
      n[8]     = q[7] ^ q[26];
      n[9]     = q[8] ^ q[26];
      n[10:26] = q[9:25];
    end
    return n;
  endfunction

  function automatic logic [25:0] ref_adv(input logic [25:0] v, input int k);
    logic [25:0] s;
    s = v;
    for (int i = 0; i < k; i++) s = ref_step(s);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Waits for any ack on the STEPS=26 instance; cyc counts edges waited.
  task automatic wait_ack(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (bus.ack == '0 && cyc < budget);
  endtask

  initial begin
    logic [25:0] w1;
    logic [25:0] w2;
    logic [25:0] exp_q;
    logic [3:0]  exp_ack;
    logic        saw_ack;
    int          cyc;

    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.req        = '0;
    bus.seed_load  = 1'b0;
    bus.seed       = '0;
    bus1.req       = '0;
    bus1.seed_load = 1'b0;
    bus1.seed      = '0;

    w1 = ref_adv(26'd1, 26);
    w2 = ref_adv(26'd1, 52);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",   32'(bus.ack),      32'h0);
    chk("rst_busy",  32'(bus.busy),     32'h0);
    chk("rst_grant", 32'(bus.grant_id), 32'h0);
    chk("rst_rnd",   32'(bus.rnd_out),  32'h0);
    rst_n = 1'b1;

    // STEPS=1, single requester 0: one step from 26'b1
    bus1.req = 4'b0001;
    @(posedge clk); #1;                 // E0
    chk("t1_busy_e0", 32'(bus1.busy), 32'h1);
    chk("t1_noack_e0", 32'(bus1.ack), 32'h0);
    @(posedge clk); #1;                 // E1
    chk("t1_ack",   32'(bus1.ack),      32'h1);
    chk("t1_rnd",   32'(bus1.rnd_out),  32'h3060000);
    chk("t1_grant", 32'(bus1.grant_id), 32'h0);
    bus1.req = '0;
    @(posedge clk); #1;
    chk("t1_ack_drop", 32'(bus1.ack),  32'h0);
    chk("t1_busy_end", 32'(bus1.busy), 32'h0);

    // STEPS=26, all requesters held: order 0,1,2,3,0, one word per 28 cycles
    exp_q   = 26'd1;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, cyc);
      exp_q   = ref_adv(exp_q, 26);
      exp_ack = 4'b0001 << (k % 4);
      chk($sformatf("t2_ack%0d", k),   32'(bus.ack),      32'(exp_ack));
      chk($sformatf("t2_grant%0d", k), 32'(bus.grant_id), 32'(k % 4));
      chk($sformatf("t2_rnd%0d", k),   32'(bus.rnd_out),  32'(exp_q));
      chk($sformatf("t2_cyc%0d", k),   32'(cyc),          (k == 0) ? 32'd27 : 32'd28);
    end
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("t2_idle", 32'(bus.busy), 32'h0);

    // Zero seed together with a request: seed wins, then the request sees 26'b1
    bus.seed_load = 1'b1;
    bus.seed      = '0;
    bus.req       = 4'b0010;
    @(posedge clk); #1;
    chk("t3_seed_wins", 32'(bus.busy), 32'h0);
    bus.seed_load = 1'b0;
    wait_ack(40, cyc);
    chk("t3_ack",   32'(bus.ack),      32'h2);
    chk("t3_grant", 32'(bus.grant_id), 32'h1);
    chk("t3_rnd",   32'(bus.rnd_out),  32'(w1));
    chk("t3_cyc",   32'(cyc),          32'd27);
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;

    // seed_load while busy is ignored: next word continues the sequence
    bus.req = 4'b0100;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("t4_busy", 32'(bus.busy), 32'h1);
    bus.seed_load = 1'b1;
    bus.seed      = 26'h155AAAA;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    wait_ack(40, cyc);
    chk("t4_ack", 32'(bus.ack),     32'h4);
    chk("t4_rnd", 32'(bus.rnd_out), 32'(w2));
    chk("t4_cyc", 32'(cyc),         32'd20);
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
`ifdef LFSR_RR_SCHED_CNT_EN
    chk("cnt_words", 32'(words_served), 32'd7);
    chk("cnt_seed",  32'(seed_seen),    32'h1);
`endif

    // Reset while stepping with cnt=10: abort with no ack, LFSR back to 26'b1
    bus.req = 4'b1000;
    saw_ack = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1;
      saw_ack = saw_ack | (bus.ack != '0);
    end
    chk("t5_no_ack_pre", 32'(saw_ack),  32'h0);
    chk("t5_busy_pre",   32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_ack",  32'(bus.ack),     32'h0);
    chk("t5_rst_busy", 32'(bus.busy),    32'h0);
    chk("t5_rst_rnd",  32'(bus.rnd_out), 32'h0);
    rst_n   = 1'b1;
    bus.req = '0;
    @(posedge clk); #1;
    chk("t5_idle_ack", 32'(bus.ack), 32'h0);
    bus.req = 4'b1000;
    wait_ack(40, cyc);
    chk("t5_ack",   32'(bus.ack),      32'h8);
    chk("t5_grant", 32'(bus.grant_id), 32'h3);
    chk("t5_rnd",   32'(bus.rnd_out),  32'(w1));
    chk("t5_cyc",   32'(cyc),          32'd27);
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
`ifdef LFSR_RR_SCHED_CNT_EN
    chk("cnt_words_after_rst", 32'(words_served), 32'd1);
    chk("cnt_seed_after_rst",  32'(seed_seen),    32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
